register_bank: RTL and testbench
================================

# register_bank

Parametrised bank of NUM_REGS general-purpose registers, each WIDTH bits wide. Every register supports the datapath's 3-bit FunSel operation set. One-hot RegSel lets a single cycle apply the same operation to several registers at once. The bank adds two independent read ports, optional saturating increment/decrement, and a registered wrap/saturate status flag. It sits between the ALU result bus and the ALU operand muxes, replacing individually instantiated 16-bit registers.

## Interface
Parameters:
- WIDTH, 16, register width in bits; even, >= 4; H = WIDTH/2 is the half-word size
- NUM_REGS, 4, number of registers; 2..16; SW = $clog2(NUM_REGS) is the select width
- SAT, 0, 0 = increment/decrement wrap modulo 2^WIDTH; 1 = increment/decrement saturate
- RESET_VALUE, 0, WIDTH-bit value loaded into every register on reset

Ports:
- Clock  in  1  single clock; all state updates on the rising edge
- Reset  in  1  reset, synchronous, active-high
- E  in  1  global write enable, active-high
- RegSel  in  NUM_REGS  one-hot-or-multi-hot register write select; bit k targets register k
- FunSel  in  3  operation select, applied to every selected register
- I  in  WIDTH  input data
- OutASel  in  SW  read port A register index
- OutBSel  in  SW  read port B register index
- OutA  out  WIDTH  contents of register OutASel
- OutB  out  WIDTH  contents of register OutBSel
- Wrap  out  1  registered status: the previous cycle's increment/decrement wrapped (SAT=0) or was clamped (SAT=1) in at least one selected register

## Operation
FunSel encoding (R = selected register, H = WIDTH/2):
- 000: R <= R - 1 (SAT=1: stays 0 when R = 0)
- 001: R <= R + 1 (SAT=1: stays all-ones when R = all-ones)
- 010: R <= I
- 011: R <= 0
- 100: R[WIDTH-1:H] <= 0; R[H-1:0] <= I[H-1:0]
- 101: R[H-1:0] <= I[H-1:0]; high half unchanged
- 110: R[WIDTH-1:H] <= I[H-1:0]; low half unchanged
- 111: R[WIDTH-1:H] <= {H{I[H-1]}}; R[H-1:0] <= I[H-1:0] (sign extend)

Write rules:
- A register updates only when Reset = 0, E = 1 and its RegSel bit = 1. Otherwise it holds.
- Several RegSel bits set: each selected register applies FunSel to its own current value independently. Decrement and increment are per register, not shared.
- RegSel = 0 with E = 1 is a legal no-op.

Wrap flag:
- Set to 1 in the next cycle when E = 1 and FunSel is 000 or 001, and at least one selected register:
  - is 0 under decrement, or
  - is all-ones under increment.
- The SAT value does not affect detection; it only decides wrap versus clamp of the stored result.
- All other cycles, including E = 0, write Wrap = 0. The flag is a one-cycle pulse per qualifying operation, not sticky.

Read ports:
- OutA and OutB are combinational from register state, not from I.
- A read and a write of the same register in the same cycle returns the old value. The new value appears after the clock edge.
- An index >= NUM_REGS (possible when NUM_REGS is not a power of two) drives all-zero.
- OutA and OutB may select the same register.

Reset:
- Reset = 1 at a rising edge: every register <= RESET_VALUE and Wrap <= 0, regardless of E, RegSel and FunSel.
- Reset has priority over any in-flight operation.
- There is no partial-operation state; the first edge after Reset deasserts performs a normal write.

## Timing
- Write latency 1 cycle: operands sampled at edge N, result visible on OutA/OutB after edge N.
- Wrap is valid after edge N for the operation sampled at edge N, and is cleared after edge N+1 unless that cycle qualifies again.
- Back-to-back operations on the same register every cycle are supported with no stall, e.g. increment on consecutive cycles counts by 1 per cycle.
- Read path is purely combinational: select to Out within the same cycle.
- No handshake; the block never back-pressures.

## Test plan
- Reset: RESET_VALUE = 16'h00A5, assert Reset 1 cycle with E = 1, FunSel = 010, I = 16'hFFFF -> all registers read 16'h00A5, Wrap = 0.
- Multi-select load/increment: RegSel = 4'b0101, FunSel = 010, I = 16'h1234; then RegSel = 4'b0001, FunSel = 001 -> R0 = 16'h1235, R2 = 16'h1234, R1 = R3 = 0, Wrap = 0 throughout.
- Half-word ops on R1 = 16'hABCD with I = 16'h0080:
  - 101 -> 16'hAB80
  - 110 -> 16'h80CD
  - 100 -> 16'h0080
  - 111 -> 16'hFF80
- Wrap, SAT = 0: R3 = 16'hFFFF, FunSel = 001 -> R3 = 16'h0000, Wrap = 1 for one cycle; then decrement -> R3 = 16'hFFFF, Wrap = 1; then E = 0 -> Wrap = 0, R3 holds.
- Saturation, SAT = 1: R0 = 0, FunSel = 000 -> R0 stays 0, Wrap = 1. R0 = 16'hFFFF, FunSel = 001 -> stays 16'hFFFF, Wrap = 1.
- Read-during-write and out-of-range, NUM_REGS = 3: OutASel = OutBSel = 1 while loading R1 with 16'h5555 over 16'h0001 -> both ports read 16'h0001 before the edge and 16'h5555 after. OutASel = 3 -> OutA = 16'h0000.

Source files
------------

// File: rtl/register_bank.sv
// Bank of NUM_REGS general-purpose registers sharing one FunSel operation set,
// with multi-hot write select, two combinational read ports and a wrap/clamp pulse.
module register_bank #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned SAT         = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int unsigned SW         = $clog2(NUM_REGS)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                E,
  input  logic [NUM_REGS-1:0] RegSel,
  input  logic [2:0]          FunSel,
  input  logic [WIDTH-1:0]    I,
  input  logic [SW-1:0]       OutASel,
  input  logic [SW-1:0]       OutBSel,
  output logic [WIDTH-1:0]    OutA,
  output logic [WIDTH-1:0]    OutB,
  output logic                Wrap
);

  localparam int unsigned H = WIDTH / 2;

  logic [WIDTH-1:0]    regs     [NUM_REGS];
  logic [WIDTH-1:0]    nxt      [NUM_REGS];
  logic [NUM_REGS-1:0] hit;

  // Per-register next value; each selected register works on its own contents.
  always_comb begin
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      nxt[k] = regs[k];
      hit[k] = 1'b0;
      if (E && RegSel[k]) begin
        case (FunSel)
          3'b000: begin
            hit[k] = (regs[k] == '0);
            nxt[k] = (SAT != 0 && hit[k]) ? regs[k] : regs[k] - WIDTH'(1);
          end
          3'b001: begin
            hit[k] = &regs[k];
            nxt[k] = (SAT != 0 && hit[k]) ? regs[k] : regs[k] + WIDTH'(1);
          end
          3'b010: nxt[k] = I;
          3'b011: nxt[k] = '0;
          3'b100: nxt[k] = {H'(0), I[H-1:0]};
          3'b101: nxt[k] = {regs[k][WIDTH-1:H], I[H-1:0]};
          3'b110: nxt[k] = {I[H-1:0], regs[k][H-1:0]};
          3'b111: nxt[k] = {{H{I[H-1]}}, I[H-1:0]};
          default: nxt[k] = regs[k];
        endcase
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VALUE;
      Wrap <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= nxt[k];
      Wrap <= |hit;
    end
  end

  // Read mux; indices past the last register fall through to zero.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (OutASel == SW'(k)) OutA = regs[k];
      if (OutBSel == SW'(k)) OutB = regs[k];
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: a 4-register wrapping bank and a 3-register saturating bank.
module tb_register_bank;

  logic Clock = 1'b0;
  logic Reset;
  always #10 Clock = ~Clock;

  logic        E0, Wrap0;
  logic [3:0]  RegSel0;
  logic [2:0]  FunSel0;
  logic [15:0] I0, OutA0, OutB0;
  logic [1:0]  OutASel0, OutBSel0;

  logic        E1, Wrap1;
  logic [2:0]  RegSel1;
  logic [2:0]  FunSel1;
  logic [15:0] I1, OutA1, OutB1;
  logic [1:0]  OutASel1, OutBSel1;

  register_bank #(.WIDTH(16), .NUM_REGS(4), .SAT(0), .RESET_VALUE(16'h00A5)) dut0 (
    .Clock(Clock), .Reset(Reset), .E(E0), .RegSel(RegSel0), .FunSel(FunSel0), .I(I0),
    .OutASel(OutASel0), .OutBSel(OutBSel0), .OutA(OutA0), .OutB(OutB0), .Wrap(Wrap0));

  register_bank #(.WIDTH(16), .NUM_REGS(3), .SAT(1), .RESET_VALUE(16'h0000)) dut1 (
    .Clock(Clock), .Reset(Reset), .E(E1), .RegSel(RegSel1), .FunSel(FunSel1), .I(I1),
    .OutASel(OutASel1), .OutBSel(OutBSel1), .OutA(OutA1), .OutB(OutB1), .Wrap(Wrap1));

  int checks = 0;
  int failures = 0;

  logic [15:0] m0 [4];
  logic [15:0] m1 [3];
  logic        mw0, mw1;

  typedef struct {
    logic        rst, e;
    logic [3:0]  sel;
    logic [2:0]  fs;
    logic [15:0] d;
    logic [15:0] r0, r1, r2, r3;
    logic        w;
  } vec_t;

  vec_t tv [19];

  function automatic vec_t mk(logic rst, logic e, logic [3:0] sel, logic [2:0] fs,
                              logic [15:0] d, logic [15:0] r0, logic [15:0] r1,
                              logic [15:0] r2, logic [15:0] r3, logic w);
    vec_t v;
    v.rst = rst; v.e = e; v.sel = sel; v.fs = fs; v.d = d;
    v.r0 = r0; v.r1 = r1; v.r2 = r2; v.r3 = r3; v.w = w;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: one register under one operation, as {wrapped, new value}.
  function automatic logic [16:0] apply(logic [15:0] v, logic [2:0] fs, logic [15:0] d, bit sat);
    int unsigned x;
    x = v;
    case (fs)
      3'd0: if (x == 0) return {1'b1, (sat ? 16'h0000 : 16'hFFFF)};
            else return {1'b0, 16'(x - 1)};
      3'd1: if (x == 65535) return {1'b1, (sat ? 16'hFFFF : 16'h0000)};
            else return {1'b0, 16'(x + 1)};
      3'd2: return {1'b0, d};
      3'd3: return 17'd0;
      3'd4: return {1'b0, d & 16'h00FF};
      3'd5: return {1'b0, (v & 16'hFF00) | (d & 16'h00FF)};
      3'd6: return {1'b0, 16'((d & 16'h00FF) * 256) | (v & 16'h00FF)};
      default: return {1'b0, (d[7] ? (d | 16'hFF00) : (d & 16'h00FF))};
    endcase
  endfunction

  // Advance both models with the current inputs across one rising edge.
  task automatic step();
    logic [15:0] n0 [4];
    logic [15:0] n1 [3];
    logic        w0, w1;
    logic [16:0] r;
    n0 = m0; n1 = m1; w0 = 1'b0; w1 = 1'b0;
    if (Reset) begin
      for (int k = 0; k < 4; k++) n0[k] = 16'h00A5;
      for (int k = 0; k < 3; k++) n1[k] = 16'h0000;
    end else begin
      if (E0) for (int k = 0; k < 4; k++) if (RegSel0[k]) begin
        r = apply(m0[k], FunSel0, I0, 1'b0); n0[k] = r[15:0]; w0 |= r[16];
      end
      if (E1) for (int k = 0; k < 3; k++) if (RegSel1[k]) begin
        r = apply(m1[k], FunSel1, I1, 1'b1); n1[k] = r[15:0]; w1 |= r[16];
      end
    end
    @(posedge Clock); #1;
    m0 = n0; m1 = n1; mw0 = w0; mw1 = w1;
  endtask

  task automatic check_model(string tag);
    chk($sformatf("%s wrap0", tag), 16'(Wrap0), 16'(mw0));
    chk($sformatf("%s wrap1", tag), 16'(Wrap1), 16'(mw1));
    for (int k = 0; k < 4; k++) begin
      OutASel0 = 2'(k); OutBSel0 = 2'(3 - k);
      if (k < 3) begin OutASel1 = 2'(k); OutBSel1 = 2'(2 - k); end
      #1;
      chk($sformatf("%s dut0 A r%0d", tag, k), OutA0, m0[k]);
      chk($sformatf("%s dut0 B r%0d", tag, 3 - k), OutB0, m0[3 - k]);
      if (k < 3) begin
        chk($sformatf("%s dut1 A r%0d", tag, k), OutA1, m1[k]);
        chk($sformatf("%s dut1 B r%0d", tag, 2 - k), OutB1, m1[2 - k]);
      end
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom % 4)
      0: return 16'h0000;
      1: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] exp_r [4];
    Reset = 1'b0;
    E0 = 1'b0; RegSel0 = '0; FunSel0 = '0; I0 = '0; OutASel0 = '0; OutBSel0 = '0;
    E1 = 1'b0; RegSel1 = '0; FunSel1 = '0; I1 = '0; OutASel1 = '0; OutBSel1 = '0;

    tv[0]  = mk(1, 1, 4'b1111, 3'd2, 16'hFFFF, 16'h00A5, 16'h00A5, 16'h00A5, 16'h00A5, 0);
    tv[1]  = mk(0, 1, 4'b1111, 3'd3, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
    tv[2]  = mk(0, 1, 4'b0101, 3'd2, 16'h1234, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 0);
    tv[3]  = mk(0, 1, 4'b0001, 3'd1, 16'h1234, 16'h1235, 16'h0000, 16'h1234, 16'h0000, 0);
    tv[4]  = mk(0, 1, 4'b0010, 3'd2, 16'hABCD, 16'h1235, 16'hABCD, 16'h1234, 16'h0000, 0);
    tv[5]  = mk(0, 1, 4'b0010, 3'd5, 16'h0080, 16'h1235, 16'hAB80, 16'h1234, 16'h0000, 0);
    tv[6]  = mk(0, 1, 4'b0010, 3'd2, 16'hABCD, 16'h1235, 16'hABCD, 16'h1234, 16'h0000, 0);
    tv[7]  = mk(0, 1, 4'b0010, 3'd6, 16'h0080, 16'h1235, 16'h80CD, 16'h1234, 16'h0000, 0);
    tv[8]  = mk(0, 1, 4'b0010, 3'd2, 16'hABCD, 16'h1235, 16'hABCD, 16'h1234, 16'h0000, 0);
    tv[9]  = mk(0, 1, 4'b0010, 3'd4, 16'h0080, 16'h1235, 16'h0080, 16'h1234, 16'h0000, 0);
    tv[10] = mk(0, 1, 4'b0010, 3'd2, 16'hABCD, 16'h1235, 16'hABCD, 16'h1234, 16'h0000, 0);
    tv[11] = mk(0, 1, 4'b0010, 3'd7, 16'h0080, 16'h1235, 16'hFF80, 16'h1234, 16'h0000, 0);
    tv[12] = mk(0, 1, 4'b1000, 3'd2, 16'hFFFF, 16'h1235, 16'hFF80, 16'h1234, 16'hFFFF, 0);
    tv[13] = mk(0, 1, 4'b1000, 3'd1, 16'h0000, 16'h1235, 16'hFF80, 16'h1234, 16'h0000, 1);
    tv[14] = mk(0, 1, 4'b1000, 3'd0, 16'h0000, 16'h1235, 16'hFF80, 16'h1234, 16'hFFFF, 1);
    tv[15] = mk(0, 0, 4'b1000, 3'd1, 16'h0000, 16'h1235, 16'hFF80, 16'h1234, 16'hFFFF, 0);
    tv[16] = mk(0, 1, 4'b0000, 3'd3, 16'h0000, 16'h1235, 16'hFF80, 16'h1234, 16'hFFFF, 0);
    tv[17] = mk(0, 1, 4'b1001, 3'd1, 16'h0000, 16'h1236, 16'hFF80, 16'h1234, 16'h0000, 1);
    tv[18] = mk(1, 1, 4'b1111, 3'd1, 16'h0000, 16'h00A5, 16'h00A5, 16'h00A5, 16'h00A5, 0);

    @(posedge Clock); #1;

    // Directed vectors on the wrapping bank.
    for (int i = 0; i < 19; i++) begin
      Reset = tv[i].rst; E0 = tv[i].e; RegSel0 = tv[i].sel; FunSel0 = tv[i].fs; I0 = tv[i].d;
      step();
      exp_r[0] = tv[i].r0; exp_r[1] = tv[i].r1; exp_r[2] = tv[i].r2; exp_r[3] = tv[i].r3;
      chk($sformatf("vec%0d wrap", i), 16'(Wrap0), 16'(tv[i].w));
      for (int k = 0; k < 4; k++) begin
        OutASel0 = 2'(k); OutBSel0 = 2'(3 - k); #1;
        chk($sformatf("vec%0d A r%0d", i, k), OutA0, exp_r[k]);
        chk($sformatf("vec%0d B r%0d", i, 3 - k), OutB0, exp_r[3 - k]);
      end
    end
    Reset = 1'b0; E0 = 1'b0;

    // Read-during-write on the 3-register bank.
    E1 = 1'b1; RegSel1 = 3'b010; FunSel1 = 3'd2; I1 = 16'h0001;
    step();
    OutASel1 = 2'd1; OutBSel1 = 2'd1; I1 = 16'h5555; #1;
    chk("rdw A before", OutA1, 16'h0001);
    chk("rdw B before", OutB1, 16'h0001);
    step();
    chk("rdw A after", OutA1, 16'h5555);
    chk("rdw B after", OutB1, 16'h5555);
    OutASel1 = 2'd3; OutBSel1 = 2'd3; #1;
    chk("oob A", OutA1, 16'h0000);
    chk("oob B", OutB1, 16'h0000);

    // Saturation at both ends.
    RegSel1 = 3'b001; FunSel1 = 3'd3; step();
    FunSel1 = 3'd0; step();
    OutASel1 = 2'd0; #1;
    chk("sat dec wrap", 16'(Wrap1), 16'h0001);
    chk("sat dec value", OutA1, 16'h0000);
    FunSel1 = 3'd2; I1 = 16'hFFFF; step();
    FunSel1 = 3'd1; step();
    OutASel1 = 2'd0; #1;
    chk("sat inc wrap", 16'(Wrap1), 16'h0001);
    chk("sat inc value", OutA1, 16'hFFFF);
    E1 = 1'b0; step();
    chk("sat pulse clear", 16'(Wrap1), 16'h0000);
    check_model("directed");

    // Random traffic on both banks against the reference model.
    for (int n = 0; n < 400; n++) begin
      Reset = ($urandom % 40) == 0;
      E0 = ($urandom % 4) != 0; RegSel0 = 4'($urandom); FunSel0 = 3'($urandom); I0 = pick();
      E1 = ($urandom % 4) != 0; RegSel1 = 3'($urandom); FunSel1 = 3'($urandom); I1 = pick();
      step();
      check_model($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
